uart_note_cmd_ctrl: RTL and testbench

//  Sequences the byte stream from the UART receiver into validated piano note commands.

---
 rtl/uart_note_cmd_ctrl_pkg.sv | 15 +
 rtl/uart_note_cmd_ctrl_cmd_fifo.sv | 64 ++++++
 rtl/uart_note_cmd_ctrl.sv | 104 ++++++++++
 tb/tb_uart_note_cmd_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_note_cmd_ctrl_pkg.sv
// rtl/uart_note_cmd_ctrl_pkg.sv - shared constants, FSM encodings and checksum helper for the note command sequencer
package uart_note_cmd_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] ST_HUNT     = 2'd0;
    localparam logic [1:0] ST_GET_NOTE = 2'd1;
    localparam logic [1:0] ST_GET_DUR  = 2'd2;
    localparam logic [1:0] ST_GET_CHK  = 2'd3;

    function automatic logic [7:0] calc_chk(input logic [7:0] note, input logic [7:0] dur);
        return note ^ dur;
    endfunction

endpackage

// File: rtl/uart_note_cmd_ctrl_cmd_fifo.sv
// rtl/uart_note_cmd_ctrl_cmd_fifo.sv - first-word-fall-through command FIFO with overflow pulse
module cmd_fifo #(
    parameter  int WIDTH = 11,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_Clock,
    input  logic             i_Rst_L,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Push_Data,
    input  logic             i_Pop_Ready,
    output logic             o_Valid,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Ovf
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_Pop_Ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push  = i_Push && (!w_full || w_pop);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= i_Push && w_full && !w_pop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_Push_Data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_Valid = !w_empty;
    assign o_Data  = r_mem[r_rd_ptr];
    assign o_Ovf   = r_ovf;

endmodule

// File: rtl/uart_note_cmd_ctrl.sv
// rtl/uart_note_cmd_ctrl.sv - frames UART bytes into checked piano note commands feeding a small FIFO
module uart_note_cmd_ctrl
    import uart_note_cmd_ctrl_pkg::*;
#(
    parameter  logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter  int         N_NOTES      = 8,
    parameter  int         TIMEOUT_CLKS = 4340,
    parameter  int         FIFO_DEPTH   = 4,
    localparam int         NW           = $clog2(N_NOTES),
    localparam int         TW           = $clog2(TIMEOUT_CLKS)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_Cmd_Valid,
    input  logic          i_Cmd_Ready,
    output logic [NW-1:0] o_Cmd_Note,
    output logic [7:0]    o_Cmd_Dur,
    output logic          o_Err_Frame,
    output logic          o_Err_Timeout,
    output logic          o_Err_Ovf,
    output logic          o_Busy
);

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    NOTE_LIMIT = 8'(N_NOTES);

    logic [1:0]    r_state;
    logic [7:0]    r_note;
    logic [7:0]    r_dur;
    logic [TW-1:0] r_timer;
    logic          r_err_frame;
    logic          r_err_timeout;

    logic          w_frame_ok;
    logic          w_push;
    logic          w_expire;
    logic [NW+7:0] w_head;

    assign w_frame_ok = (calc_chk(r_note, r_dur) == i_RX_Byte) && (r_note < NOTE_LIMIT);
    assign w_push     = (r_state == ST_GET_CHK) && i_RX_DV && w_frame_ok;
    // A byte arriving on the expiry cycle is still accepted
    assign w_expire   = (r_state != ST_HUNT) && !i_RX_DV && (r_timer == TIMER_LAST);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state       <= ST_HUNT;
            r_note        <= 8'h00;
            r_dur         <= 8'h00;
            r_timer       <= '0;
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
            if (r_state == ST_HUNT) begin
                r_timer <= '0;
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    r_state <= ST_GET_NOTE;
                end
            end else if (i_RX_DV) begin
                r_timer <= '0;
                if (r_state == ST_GET_NOTE) begin
                    r_note  <= i_RX_Byte;
                    r_state <= ST_GET_DUR;
                end else if (r_state == ST_GET_DUR) begin
                    r_dur   <= i_RX_Byte;
                    r_state <= ST_GET_CHK;
                end else begin
                    r_err_frame <= !w_frame_ok;
                    r_state     <= ST_HUNT;
                end
            end else if (w_expire) begin
                r_err_timeout <= 1'b1;
                r_timer       <= '0;
                r_state       <= ST_HUNT;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    cmd_fifo #(
        .WIDTH (NW + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_Push      (w_push),
        .i_Push_Data ({r_note[NW-1:0], r_dur}),
        .i_Pop_Ready (i_Cmd_Ready),
        .o_Valid     (o_Cmd_Valid),
        .o_Data      (w_head),
        .o_Ovf       (o_Err_Ovf)
    );

    assign o_Cmd_Note    = w_head[NW+7:8];
    assign o_Cmd_Dur     = w_head[7:0];
    assign o_Err_Frame   = r_err_frame;
    assign o_Err_Timeout = r_err_timeout;
    assign o_Busy        = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_note_cmd_ctrl.sv
// tb/tb_uart_note_cmd_ctrl.sv - directed self-checking bench for uart_note_cmd_ctrl
module tb_uart_note_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_note;
    logic [7:0] cmd_dur;
    logic       err_frame;
    logic       err_timeout;
    logic       err_ovf;
    logic       busy;

    int n_total;
    int n_pass;
    int n_fail;
    int n_wait;

    uart_note_cmd_ctrl dut (
        .i_Clock       (clk),
        .i_Rst_L       (rst_n),
        .i_RX_DV       (rx_dv),
        .i_RX_Byte     (rx_byte),
        .o_Cmd_Valid   (cmd_valid),
        .i_Cmd_Ready   (cmd_ready),
        .o_Cmd_Note    (cmd_note),
        .o_Cmd_Dur     (cmd_dur),
        .o_Err_Frame   (err_frame),
        .o_Err_Timeout (err_timeout),
        .o_Err_Ovf     (err_ovf),
        .o_Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] note, input logic [7:0] dur);
        send_byte(8'hA5);
        send_byte(note);
        send_byte(dur);
        send_byte(note ^ dur);
    endtask

    task automatic check_errs_clear(input string tag);
        check(tag, {29'd0, err_frame, err_timeout, err_ovf}, 32'd0);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        tick(3);
        check("rst_valid", cmd_valid, 0);
        check("rst_note", cmd_note, 0);
        check("rst_dur", cmd_dur, 0);
        check("rst_busy", busy, 0);
        check_errs_clear("rst_errs");
        rst_n = 1'b1;
        tick(1);

        // 1: basic good frame, consumer always ready
        cmd_ready = 1'b1;
        send_byte(8'hA5);
        check("t1_busy", busy, 1);
        send_byte(8'h03);
        send_byte(8'h40);
        send_byte(8'h43);
        check("t1_valid", cmd_valid, 1);
        check("t1_note", cmd_note, 3);
        check("t1_dur", cmd_dur, 32'h40);
        check_errs_clear("t1_errs");
        check("t1_busy_done", busy, 0);
        tick(1);
        check("t1_popped", cmd_valid, 0);

        // 2: bad checksum, then a good frame
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h40);
        send_byte(8'h44);
        check("t2_err_frame", err_frame, 1);
        check("t2_no_push", cmd_valid, 0);
        tick(1);
        check("t2_err_one_cycle", err_frame, 0);
        send_frame(8'h01, 8'h02);
        check("t2_valid", cmd_valid, 1);
        check("t2_note", cmd_note, 1);
        check("t2_dur", cmd_dur, 2);
        tick(1);

        // 3: leading junk ignored, note out of range rejected
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t3_junk_busy", busy, 0);
        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'h10);
        send_byte(8'h19);
        check("t3_err_frame", err_frame, 1);
        check("t3_no_push", cmd_valid, 0);
        tick(1);

        // 4: inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h02);
        n_wait = 0;
        while (!err_timeout && n_wait < 5000) begin
            tick(1);
            n_wait++;
        end
        check("t4_timeout_latency", n_wait, 4340);
        check("t4_busy_fall", busy, 0);
        check("t4_no_frame_err", err_frame, 0);
        tick(1);
        check("t4_timeout_one_cycle", err_timeout, 0);
        send_frame(8'h05, 8'h07);
        check("t4_valid", cmd_valid, 1);
        check("t4_note", cmd_note, 5);
        check("t4_dur", cmd_dur, 7);
        tick(1);

        // 4b: byte on the expiry cycle wins over the timeout
        send_byte(8'hA5);
        tick(4339);
        check("t4b_not_early", err_timeout, 0);
        send_byte(8'h06);
        check("t4b_no_timeout", err_timeout, 0);
        check("t4b_busy", busy, 1);
        send_byte(8'h33);
        send_byte(8'h35);
        check("t4b_valid", cmd_valid, 1);
        check("t4b_note", cmd_note, 6);
        check("t4b_dur", cmd_dur, 32'h33);
        tick(1);

        // 5: fill the FIFO and overflow on the fifth frame
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(i), 8'(8'h10 + i));
        end
        check("t5_ovf", err_ovf, 1);
        check("t5_valid", cmd_valid, 1);
        check("t5_head", cmd_note, 0);
        tick(1);
        check("t5_ovf_one_cycle", err_ovf, 0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_pop_note", cmd_note, i);
            check("t5_pop_dur", cmd_dur, 32'h10 + i);
            tick(1);
        end
        check("t5_drained", cmd_valid, 0);

        // 5b: pop coincident with the push into a full FIFO
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(i), 8'(8'h20 + i));
        end
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h24);
        cmd_ready = 1'b1;
        send_byte(8'h20);
        cmd_ready = 1'b0;
        check("t5b_no_ovf", err_ovf, 0);
        check("t5b_head", cmd_note, 1);
        cmd_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("t5b_pop_note", cmd_note, i);
            check("t5b_pop_dur", cmd_dur, 32'h20 + i);
            tick(1);
        end
        check("t5b_drained", cmd_valid, 0);

        // 6: reset mid-frame clears the FIFO and partial frame
        cmd_ready = 1'b0;
        send_frame(8'h02, 8'h02);
        check("t6_queued", cmd_valid, 1);
        send_byte(8'hA5);
        send_byte(8'h03);
        check("t6_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", cmd_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_note", cmd_note, 0);
        check("t6_rst_dur", cmd_dur, 0);
        check_errs_clear("t6_rst_errs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        send_byte(8'h03);
        send_byte(8'h40);
        send_byte(8'h43);
        check("t6_tail_no_cmd", cmd_valid, 0);
        check("t6_tail_no_err", err_frame, 0);
        check("t6_tail_busy", busy, 0);
        send_frame(8'h06, 8'h01);
        check("t6_valid", cmd_valid, 1);
        check("t6_note", cmd_note, 6);
        check("t6_dur", cmd_dur, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
